// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler.
// Frame layout: header, source id, payload bytes MSB first, checksum.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StId,
      StFetch,
      StHi,
      StLo,
      StCsum,
      StGap
   } state_e;

   localparam logic [7:0] DefHdrByte = 8'hA5;
   // Header, id and checksum bytes wrapped around the payload.
   localparam int unsigned FrameOverhead = 3;
   localparam int unsigned GrantIdW = 2;

endpackage

// File: rtl/uart_frame_sched_if.sv
// Word-stream requester bundle plus the UART TX byte port.
// The master modport is the scheduler side; slave is the producers/transmitter side.
interface uart_frame_sched_if #(
   parameter int unsigned N_SRC = 2
) ();

   logic [N_SRC-1:0]    src_valid;
   logic [16*N_SRC-1:0] src_data;
   logic [N_SRC-1:0]    src_ready;
   logic [7:0]          m_tx_data;
   logic                m_tx_valid;
   logic                m_tx_ready;

   modport master (
      input  src_valid,
      input  src_data,
      output src_ready,
      output m_tx_data,
      output m_tx_valid,
      input  m_tx_ready
   );

   modport slave (
      output src_valid,
      output src_data,
      input  src_ready,
      input  m_tx_data,
      input  m_tx_valid,
      output m_tx_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer itself is owned and updated by the parent.
module rr_arbiter
   import uart_frame_pkg::*;
#(
   parameter int unsigned N_SRC = 2
) (
   input  logic [N_SRC-1:0]    req,
   input  logic [GrantIdW-1:0] ptr,
   output logic [N_SRC-1:0]    gnt,
   output logic [GrantIdW-1:0] gnt_id,
   output logic                gnt_valid
);

   localparam int NSrc = int'(N_SRC);

   always_comb begin
      int idx;
      idx       = 0;
      gnt       = '0;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      // Walk from the farthest offset down so the nearest requester wins last.
      for (int off = NSrc - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NSrc;
         if (req[idx]) begin
            gnt       = '0;
            gnt[idx]  = 1'b1;
            gnt_id    = GrantIdW'(idx);
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin frame scheduler: serialises one fixed-length frame per grant onto the
// UART TX byte port, with a holdoff after each byte to mask the transmitter's lagging ready.
module uart_frame_sched
   import uart_frame_pkg::*;
#(
   parameter int unsigned N_SRC       = 2,
   parameter int unsigned FRAME_WORDS = 4,
   parameter logic [7:0]  HDR_BYTE    = DefHdrByte,
   parameter int unsigned HOLDOFF     = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   uart_frame_sched_if.master  bus,
   output logic                busy,
   output logic [GrantIdW-1:0] grant_id,
   output logic                frame_done
);

   localparam int NSrc  = int'(N_SRC);
   localparam int HoldW = $clog2(HOLDOFF + 2);

   state_e              state_q, state_d;
   logic                tx_valid_q, tx_valid_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic [HoldW-1:0]    hold_q, hold_d;
   logic [7:0]          csum_q, csum_d;
   logic [15:0]         word_q, word_d;
   logic [7:0]          words_q, words_d;
   logic                busy_q, busy_d;
   logic [GrantIdW-1:0] grant_q, grant_d;
   logic [N_SRC-1:0]    gnt_oh_q, gnt_oh_d;
   logic [GrantIdW-1:0] ptr_q, ptr_d;
   logic                done_q, done_d;

   logic [N_SRC-1:0]    arb_gnt;
   logic [GrantIdW-1:0] arb_id;
   logic                arb_valid;
   logic [15:0]         sel_word;
   logic                hs;
   logic                load_ok;
   logic                src_hs;

   rr_arbiter #(
      .N_SRC (N_SRC)
   ) u_arb (
      .req       (bus.src_valid),
      .ptr       (ptr_q),
      .gnt       (arb_gnt),
      .gnt_id    (arb_id),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NSrc; k++) begin
         if (gnt_oh_q[k]) sel_word = bus.src_data[16*k +: 16];
      end
   end

   // Only the granted source sees ready, and only while fetching.
   assign bus.src_ready = (state_q == StFetch) ? (gnt_oh_q & bus.src_valid) : '0;
   assign src_hs        = |bus.src_ready;

   assign hs      = tx_valid_q && bus.m_tx_ready;
   assign load_ok = !tx_valid_q && (hold_q <= HoldW'(1));

   always_comb begin
      state_d    = state_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      hold_d     = (hold_q != '0) ? hold_q - 1'b1 : '0;
      csum_d     = csum_q;
      word_d     = word_q;
      words_d    = words_q;
      busy_d     = busy_q;
      grant_d    = grant_q;
      gnt_oh_d   = gnt_oh_q;
      ptr_d      = ptr_q;
      done_d     = 1'b0;

      if (hs) begin
         tx_valid_d = 1'b0;
         hold_d     = HoldW'(HOLDOFF);
      end

      unique case (state_q)
         StIdle: begin
            if (en && arb_valid && (hold_q <= HoldW'(1))) begin
               grant_d    = arb_id;
               gnt_oh_d   = arb_gnt;
               busy_d     = 1'b1;
               csum_d     = '0;
               words_d    = '0;
               tx_valid_d = 1'b1;
               tx_data_d  = HDR_BYTE;
               state_d    = StHdr;
            end
         end
         StHdr: begin
            if (hs) state_d = StId;
         end
         StId: begin
            if (hs) begin
               csum_d  = csum_q + tx_data_q;
               state_d = StFetch;
            end else if (load_ok) begin
               tx_valid_d = 1'b1;
               tx_data_d  = {6'b0, grant_q};
            end
         end
         StFetch: begin
            if (src_hs) begin
               word_d  = sel_word;
               state_d = StHi;
            end
         end
         StHi: begin
            if (hs) begin
               csum_d  = csum_q + tx_data_q;
               state_d = StLo;
            end else if (load_ok) begin
               tx_valid_d = 1'b1;
               tx_data_d  = word_q[15:8];
            end
         end
         StLo: begin
            if (hs) begin
               csum_d  = csum_q + tx_data_q;
               words_d = words_q + 8'd1;
               if (({1'b0, words_q} + 9'd1) < 9'(FRAME_WORDS)) state_d = StFetch;
               else                                            state_d = StCsum;
            end else if (load_ok) begin
               tx_valid_d = 1'b1;
               tx_data_d  = word_q[7:0];
            end
         end
         StCsum: begin
            if (hs) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ptr_d   = (int'(grant_q) >= NSrc - 1) ? '0 : grant_q + GrantIdW'(1);
               state_d = StGap;
            end else if (load_ok) begin
               tx_valid_d = 1'b1;
               tx_data_d  = csum_q;
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         hold_q     <= '0;
         csum_q     <= '0;
         word_q     <= '0;
         words_q    <= '0;
         busy_q     <= 1'b0;
         grant_q    <= '0;
         gnt_oh_q   <= '0;
         ptr_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         hold_q     <= hold_d;
         csum_q     <= csum_d;
         word_q     <= word_d;
         words_q    <= words_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         gnt_oh_q   <= gnt_oh_d;
         ptr_q      <= ptr_d;
         done_q     <= done_d;
      end
   end

   assign bus.m_tx_valid = tx_valid_q;
   assign bus.m_tx_data  = tx_data_q;
   assign busy           = busy_q;
   assign grant_id       = grant_q;
   assign frame_done     = done_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched: table of single frames plus hand-written
// sequences for arbitration order, lagging ready, source stall, enable and mid-frame reset.
module tb_uart_frame_sched;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       busy;
   logic [1:0] grant_id;
   logic       frame_done;

   uart_frame_sched_if #(.N_SRC(2)) bus ();

   uart_frame_sched #(
      .N_SRC       (2),
      .FRAME_WORDS (2),
      .HDR_BYTE    (8'hA5),
      .HOLDOFF     (2)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .bus        (bus.master),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   typedef struct {
      int          src;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0]  csum;
   } vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [7:0]  cap[$];
   int          pc0 = 0;
   int          stall_at0 = -1;
   int          stall_len0 = 0;
   bit          lag_mode = 0;
   bit          just_acc = 0;
   bit          pend_drop = 0;
   int          lag_cnt = 0;
   int          done_cnt = 0;
   int          stab_err = 0;
   int          rdy_err = 0;
   int          busy_err = 0;
   int          stall_err = 0;
   logic        prev_v = 0;
   logic        prev_hs = 0;
   logic [7:0]  prev_d = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // One cycle of source, sink and monitor models; inputs change at negedge.
   task automatic step();
      logic       v0;
      logic       v1;
      logic       hs;
      logic [1:0] ok_mask;
      @(negedge clk);
      if (lag_mode) begin
         if (pend_drop) begin
            bus.m_tx_ready = 1'b0;
            lag_cnt        = 5000;
            pend_drop      = 0;
         end else if (just_acc) begin
            just_acc  = 0;
            pend_drop = 1;
         end else if (!bus.m_tx_ready) begin
            if (lag_cnt == 0) bus.m_tx_ready = 1'b1;
            else lag_cnt--;
         end
      end else begin
         bus.m_tx_ready = 1'b1;
      end
      v0 = (q0.size() > 0);
      v1 = (q1.size() > 0);
      if (v0 && pc0 == stall_at0 && stall_len0 > 0) begin
         v0 = 1'b0;
         stall_len0--;
         if (stall_len0 < 30 && (bus.m_tx_valid || !busy)) stall_err++;
      end
      bus.src_valid = {v1, v0};
      bus.src_data  = {v1 ? q1[0] : 16'h0, v0 ? q0[0] : 16'h0};
      #1;
      hs = bus.m_tx_valid && bus.m_tx_ready;
      if (hs) begin
         cap.push_back(bus.m_tx_data);
         if (lag_mode) just_acc = 1;
      end
      if (rstn && prev_v && !prev_hs && (!bus.m_tx_valid || bus.m_tx_data != prev_d)) stab_err++;
      prev_v  = rstn && bus.m_tx_valid;
      prev_d  = bus.m_tx_data;
      prev_hs = hs;
      ok_mask = busy ? (2'b01 << grant_id) : 2'b00;
      if ((bus.src_ready & ~ok_mask) != 2'b00) rdy_err++;
      if (bus.src_ready[0]) begin
         q0.delete(0);
         pc0++;
      end
      if (bus.src_ready[1]) q1.delete(0);
      if (frame_done) begin
         done_cnt++;
         if (busy) busy_err++;
      end
   endtask

   task automatic run_frames(input string tag, input int target, input int bound);
      int start;
      start = done_cnt;
      for (int i = 0; i < bound && done_cnt < start + target; i++) step();
      chk({tag, "_frames_done"}, done_cnt - start, target);
   endtask

   task automatic check_frame(input string tag, input int src, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [7:0] csum, input int base);
      logic [7:0] e[7];
      e[0] = 8'hA5;
      e[1] = 8'(src);
      e[2] = w0[15:8];
      e[3] = w0[7:0];
      e[4] = w1[15:8];
      e[5] = w1[7:0];
      e[6] = csum;
      for (int i = 0; i < 7; i++) begin
         if (base + i < cap.size()) chk($sformatf("%s_byte%0d", tag, i), int'(cap[base + i]),
                                        int'(e[i]));
         else chk($sformatf("%s_byte%0d_missing", tag, i), -1, int'(e[i]));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_m_tx_valid"}, int'(bus.m_tx_valid), 0);
      chk({tag, "_m_tx_data"}, int'(bus.m_tx_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_grant_id"}, int'(grant_id), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_src_ready"}, int'(bus.src_ready), 0);
   endtask

   initial begin
      vec_t vecs[6];
      int   start;
      int   seen;
      vecs[0] = '{src: 0, w0: 16'h1234, w1: 16'h5678, csum: 8'h14};
      vecs[1] = '{src: 1, w0: 16'hABCD, w1: 16'hEF01, csum: 8'h69};
      vecs[2] = '{src: 0, w0: 16'hFFFF, w1: 16'hFFFF, csum: 8'hFC};
      vecs[3] = '{src: 1, w0: 16'h0000, w1: 16'h0000, csum: 8'h01};
      vecs[4] = '{src: 0, w0: 16'h0001, w1: 16'h8000, csum: 8'h81};
      vecs[5] = '{src: 1, w0: 16'h00FF, w1: 16'hFF00, csum: 8'hFF};

      rstn           = 1'b0;
      en             = 1'b0;
      bus.src_valid  = '0;
      bus.src_data   = '0;
      bus.m_tx_ready = 1'b1;
      repeat (3) step();
      chk_reset("reset");

      rstn = 1'b1;
      en   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cap.delete();
         if (vecs[i].src == 0) begin
            q0.push_back(vecs[i].w0);
            q0.push_back(vecs[i].w1);
         end else begin
            q1.push_back(vecs[i].w0);
            q1.push_back(vecs[i].w1);
         end
         start = done_cnt;
         run_frames($sformatf("vec%0d", i), 1, 200);
         check_frame($sformatf("vec%0d", i), vecs[i].src, vecs[i].w0, vecs[i].w1,
                     vecs[i].csum, 0);
         chk($sformatf("vec%0d_grant_id", i), int'(grant_id), vecs[i].src);
         repeat (5) step();
         chk($sformatf("vec%0d_single_pulse", i), done_cnt - start, 1);
         chk($sformatf("vec%0d_nbytes", i), cap.size(), 7);
      end

      // Both sources valid straight after reset: src0 first, frames back to back.
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      cap.delete();
      q0.push_back(16'h1111);
      q0.push_back(16'h2222);
      q1.push_back(16'h3333);
      q1.push_back(16'h4444);
      run_frames("both", 2, 400);
      check_frame("both_src0", 0, 16'h1111, 16'h2222, 8'h66, 0);
      check_frame("both_src1", 1, 16'h3333, 16'h4444, 8'hEF, 7);
      chk("both_nbytes", cap.size(), 14);

      // Transmitter whose ready lingers one cycle after each accept, slow byte time.
      lag_mode       = 1;
      just_acc       = 0;
      pend_drop      = 0;
      lag_cnt        = 10;
      bus.m_tx_ready = 1'b0;
      cap.delete();
      q0.push_back(16'h1234);
      q0.push_back(16'h5678);
      run_frames("lag", 1, 40000);
      repeat (20) step();
      check_frame("lag", 0, 16'h1234, 16'h5678, 8'h14, 0);
      chk("lag_nbytes", cap.size(), 7);
      lag_mode = 0;

      // Enable low holds off arbitration; raising it starts src1 promptly.
      en = 1'b0;
      cap.delete();
      q1.push_back(16'h5555);
      q1.push_back(16'h6666);
      repeat (20) step();
      chk("en_low_busy", int'(busy), 0);
      chk("en_low_m_tx_valid", int'(bus.m_tx_valid), 0);
      chk("en_low_src_ready", int'(bus.src_ready), 0);
      chk("en_low_grant_id", int'(grant_id), 0);
      en   = 1'b1;
      seen = 0;
      for (int i = 0; i < 3 && seen == 0; i++) begin
         step();
         if (bus.m_tx_valid) seen = 1;
      end
      chk("en_hdr_within3", seen, 1);
      en = 1'b0;
      run_frames("en", 1, 200);
      check_frame("en", 1, 16'h5555, 16'h6666, 8'h77, 0);
      en = 1'b1;

      // Source drops valid for 50 cycles before its second word.
      cap.delete();
      pc0        = 0;
      stall_at0  = 1;
      stall_len0 = 50;
      q0.push_back(16'h0A0B);
      q0.push_back(16'h0C0D);
      run_frames("stall", 1, 400);
      check_frame("stall", 0, 16'h0A0B, 16'h0C0D, 8'h2E, 0);
      chk("stall_consumed", stall_len0, 0);
      stall_at0 = -1;

      // Reset while the HI byte is on the port; pointer must return to src0.
      cap.delete();
      q0.push_back(16'h9A9A);
      q0.push_back(16'h1111);
      for (int i = 0; i < 60 && cap.size() < 3; i++) step();
      chk("mid_hi_seen", cap.size(), 3);
      rstn = 1'b0;
      step();
      chk_reset("midreset");
      q0.delete();
      cap.delete();
      q0.push_back(16'h1357);
      q0.push_back(16'h2468);
      q1.push_back(16'h0102);
      q1.push_back(16'h0304);
      rstn = 1'b1;
      run_frames("post_reset", 2, 400);
      check_frame("post_reset_src0", 0, 16'h1357, 16'h2468, 8'hF6, 0);
      check_frame("post_reset_src1", 1, 16'h0102, 16'h0304, 8'h0B, 7);

      chk("tx_hold_stable", stab_err, 0);
      chk("src_ready_granted_only", rdy_err, 0);
      chk("busy_low_at_done", busy_err, 0);
      chk("stall_tx_idle", stall_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
